// File: rtl/hazard_unit_if.sv
// Hazard-unit bundle: per-stage control bits and register tags going in,
// stall/flush/forward controls, memory-timeout flag and event counters coming out.
interface hazard_unit_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       rsD, rtD, rsE, rtE;
    logic [4:0]       writeregE, writeregM, writeregW;
    logic             branchD, regwriteE, memtoregE;
    logic             regwriteM, memtoregM, regwriteW;
    logic             memReqM, memReadyM;
    logic             stallF, stallD, stallE, stallM;
    logic             flushE, flushW;
    logic             forwardAD, forwardBD;
    logic [1:0]       forwardAE, forwardBE;
    logic             memErr;
    logic [CNT_W-1:0] lwStallCnt, branchStallCnt, memWaitCnt;

    modport slave (
        input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
               branchD, regwriteE, memtoregE, regwriteM, memtoregM, regwriteW,
               memReqM, memReadyM,
        output stallF, stallD, stallE, stallM, flushE, flushW,
               forwardAD, forwardBD, forwardAE, forwardBE,
               memErr, lwStallCnt, branchStallCnt, memWaitCnt
    );

    modport master (
        output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
               branchD, regwriteE, memtoregE, regwriteM, memtoregM, regwriteW,
               memReqM, memReadyM,
        input  stallF, stallD, stallE, stallM, flushE, flushW,
               forwardAD, forwardBD, forwardAE, forwardBE,
               memErr, lwStallCnt, branchStallCnt, memWaitCnt
    );
endinterface

// File: rtl/hazard_unit.sv
// Five-stage MIPS hazard responder: forwarding, load-use/branch stalls, data-memory
// wait FSM with sticky timeout. Stall-event counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_unit #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 16
) (
    input logic         clk,
    input logic         reset,
    hazard_unit_if.slave hz
);

    typedef enum logic {ST_RUN, ST_WAIT} state_t;

    state_t     state, stateNext;
    logic [7:0] waitCnt, waitNext;
    logic       memErrQ, memErrNext;
    logic       lwStall, branchStall, memStall;

    function automatic logic [1:0] fwdSel(input logic [4:0] src, input logic [4:0] wrM,
                                          input logic rwM, input logic [4:0] wrW,
                                          input logic rwW);
        if (src != 5'd0 && src == wrM && rwM)
            return 2'b10;
        else if (src != 5'd0 && src == wrW && rwW)
            return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        lwStall     = hz.memtoregE & ((hz.rtE == hz.rsD) | (hz.rtE == hz.rtD));
        branchStall = hz.branchD &
                      ((hz.regwriteE & ((hz.writeregE == hz.rsD) | (hz.writeregE == hz.rtD))) |
                       (hz.memtoregM & ((hz.writeregM == hz.rsD) | (hz.writeregM == hz.rtD))));
        memStall    = hz.memReqM & ~hz.memReadyM;
    end

    // Memory freeze outranks the load-use/branch bubble; the bubble is taken once the wait ends.
    always_comb begin
        hz.stallF    = 1'b0;
        hz.stallD    = 1'b0;
        hz.stallE    = 1'b0;
        hz.stallM    = 1'b0;
        hz.flushE    = 1'b0;
        hz.flushW    = 1'b0;
        hz.forwardAD = 1'b0;
        hz.forwardBD = 1'b0;
        hz.forwardAE = 2'b00;
        hz.forwardBE = 2'b00;
        if (reset) begin
            hz.forwardAE = fwdSel(hz.rsE, hz.writeregM, hz.regwriteM, hz.writeregW, hz.regwriteW);
            hz.forwardBE = fwdSel(hz.rtE, hz.writeregM, hz.regwriteM, hz.writeregW, hz.regwriteW);
            hz.forwardAD = (hz.rsD != 5'd0) & (hz.rsD == hz.writeregM) & hz.regwriteM;
            hz.forwardBD = (hz.rtD != 5'd0) & (hz.rtD == hz.writeregM) & hz.regwriteM;
            if (memStall) begin
                hz.stallF = 1'b1;
                hz.stallD = 1'b1;
                hz.stallE = 1'b1;
                hz.stallM = 1'b1;
                hz.flushW = 1'b1;
            end else if (lwStall | branchStall) begin
                hz.stallF = 1'b1;
                hz.stallD = 1'b1;
                hz.flushE = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_RUN;
            waitCnt <= 8'd0;
            memErrQ <= 1'b0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitNext;
            memErrQ <= memErrNext;
        end
    end

    // waitCnt holds the number of completed stall cycles, so WAIT_LIMIT-1 marks the last tolerated one.
    always_comb begin
        stateNext  = state;
        waitNext   = 8'd0;
        memErrNext = memErrQ;
        if (memStall && waitCnt == 8'(WAIT_LIMIT - 1))
            memErrNext = 1'b1;
        case (state)
            ST_RUN: begin
                if (memStall) begin
                    stateNext = ST_WAIT;
                    waitNext  = 8'd1;
                end
            end
            ST_WAIT: begin
                if (memStall)
                    waitNext = (waitCnt < 8'(WAIT_LIMIT)) ? waitCnt + 8'd1 : waitCnt;
                else
                    stateNext = ST_RUN;
            end
            default: stateNext = ST_RUN;
        endcase
    end

    assign hz.memErr = memErrQ;

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] lwCnt, brCnt, mwCnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lwCnt <= '0;
            brCnt <= '0;
            mwCnt <= '0;
        end else begin
            if (lwStall && !memStall && lwCnt != CNT_MAX)
                lwCnt <= lwCnt + CNT_ONE;
            if (branchStall && !lwStall && !memStall && brCnt != CNT_MAX)
                brCnt <= brCnt + CNT_ONE;
            if (memStall && mwCnt != CNT_MAX)
                mwCnt <= mwCnt + CNT_ONE;
        end
    end

    assign hz.lwStallCnt     = lwCnt;
    assign hz.branchStallCnt = brCnt;
    assign hz.memWaitCnt     = mwCnt;
`else
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    assign hz.lwStallCnt     = CNT_ZERO;
    assign hz.branchStallCnt = CNT_ZERO;
    assign hz.memWaitCnt     = CNT_ZERO;
`endif

endmodule
